// File: rtl/riscv_ctrl_pkg.sv
// Shared state, opcode and control-field encodings for the multicycle RISC-V main controller.
package riscv_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      TRAP
   } ctrl_state_t;

   localparam logic [6:0] OP_R_TYPE = 7'b0110011;
   localparam logic [6:0] OP_I_TYPE = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] ALU_OP_ADD    = 3'b000;
   localparam logic [2:0] ALU_OP_BRANCH = 3'b001;
   localparam logic [2:0] ALU_OP_RTYPE  = 3'b010;
   localparam logic [2:0] ALU_OP_ITYPE  = 3'b011;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_FOUR = 2'b01;
   localparam logic [1:0] SRC_B_IMM  = 2'b10;

   localparam logic [1:0] WB_ALU_OUT  = 2'b00;
   localparam logic [1:0] WB_MDR      = 2'b01;
   localparam logic [1:0] WB_PC_PLUS4 = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   typedef struct packed {
      logic r_type;
      logic i_type;
      logic load;
      logic store;
      logic branch;
      logic jal;
   } instr_class_t;

   localparam int unsigned CLASS_W = $bits(instr_class_t);

   function automatic logic is_mem_class(instr_class_t c);
      return c.load | c.store;
   endfunction

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode classifier: one-hot instruction class plus an illegal-opcode flag.
module main_decoder
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W = 7
) (
   input  logic [OPCODE_W-1:0] opcode,
   output logic [CLASS_W-1:0]  cls,
   output logic                illegal
);

   instr_class_t c;

   always_comb begin
      c       = '0;
      illegal = 1'b0;
      case (opcode)
         OPCODE_W'(OP_R_TYPE): c.r_type = 1'b1;
         OPCODE_W'(OP_I_TYPE): c.i_type = 1'b1;
         OPCODE_W'(OP_LOAD):   c.load   = 1'b1;
         OPCODE_W'(OP_STORE):  c.store  = 1'b1;
         OPCODE_W'(OP_BRANCH): c.branch = 1'b1;
         OPCODE_W'(OP_JAL):    c.jal    = 1'b1;
         default:              illegal  = 1'b1;
      endcase
   end

   assign cls = c;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V main control FSM: sequences fetch/decode/exec/mem/writeback against a
// variable-latency memory, trapping on illegal opcodes and memory timeouts.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W    = 7,
   parameter int unsigned ALUOP_W     = 3,
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned TO_CNT_W    = 5
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                halt,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                alu_zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                i_or_d,
   output logic                ir_write,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic [1:0]          mem_to_reg,
   output logic                reg_write,
   output logic                busy,
   output logic                instr_done,
   output logic                trap,
   output logic [1:0]          trap_cause
);

   ctrl_state_t         state_q, state_d, next_fetch;
   logic [OPCODE_W-1:0] opcode_q, opcode_d;
   logic [TO_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [1:0]          cause_q, cause_d;
   logic [2:0]          alu_op_sel;
   logic                timeout_hit;

   logic [CLASS_W-1:0]  cls_q_raw;
   instr_class_t        cls_q;
   logic                illegal_live;
   logic [CLASS_W-1:0]  unused_cls_live;
   logic                unused_illegal_q;
   logic                unused_alu_zero;

   // The branch-taken qualification happens in the datapath PC enable, not here.
   assign unused_alu_zero = alu_zero;

   main_decoder #(
      .OPCODE_W (OPCODE_W)
   ) u_dec_latched (
      .opcode  (opcode_q),
      .cls     (cls_q_raw),
      .illegal (unused_illegal_q)
   );

   main_decoder #(
      .OPCODE_W (OPCODE_W)
   ) u_dec_live (
      .opcode  (opcode),
      .cls     (unused_cls_live),
      .illegal (illegal_live)
   );

   assign cls_q = instr_class_t'(cls_q_raw);

   // Wait-cycle counter saturates at all-ones; the limit compares against the incremented value
   // so the trap fires at the end of the MEM_TIMEOUT-th wait cycle.
   assign cnt_inc     = (cnt_q == {TO_CNT_W{1'b1}}) ? cnt_q : cnt_q + TO_CNT_W'(1);
   assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_inc == TO_CNT_W'(MEM_TIMEOUT));
   assign next_fetch  = halt ? IDLE : FETCH;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         opcode_q <= '0;
         cnt_q    <= '0;
         cause_q  <= CAUSE_NONE;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         cnt_q    <= cnt_d;
         cause_q  <= cause_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      opcode_d      = opcode_q;
      cnt_d         = '0;
      cause_d       = cause_q;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRC_B_RS2;
      alu_op_sel    = ALU_OP_ADD;
      mem_to_reg    = WB_ALU_OUT;
      reg_write     = 1'b0;
      instr_done    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!halt) state_d = FETCH;
         end
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               alu_src_b = SRC_B_FOUR;
               state_d   = DECODE;
            end else begin
               cnt_d = cnt_inc;
               if (timeout_hit) begin
                  state_d = TRAP;
                  cause_d = CAUSE_TIMEOUT;
               end
            end
         end
         DECODE: begin
            opcode_d  = opcode;
            alu_src_b = SRC_B_IMM;
            if (illegal_live) begin
               state_d = TRAP;
               cause_d = CAUSE_ILLEGAL;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            unique case (1'b1)
               cls_q.r_type: begin
                  alu_src_a  = 1'b1;
                  alu_op_sel = ALU_OP_RTYPE;
                  state_d    = WB;
               end
               cls_q.i_type: begin
                  alu_src_a  = 1'b1;
                  alu_src_b  = SRC_B_IMM;
                  alu_op_sel = ALU_OP_ITYPE;
                  state_d    = WB;
               end
               is_mem_class(cls_q): begin
                  alu_src_a = 1'b1;
                  alu_src_b = SRC_B_IMM;
                  state_d   = MEM;
               end
               cls_q.branch: begin
                  alu_src_a     = 1'b1;
                  alu_op_sel    = ALU_OP_BRANCH;
                  pc_write_cond = 1'b1;
                  instr_done    = 1'b1;
                  state_d       = next_fetch;
               end
               cls_q.jal: begin
                  // Target was left in ALUOut by DECODE.
                  pc_write = 1'b1;
                  state_d  = WB;
               end
               default: begin
                  state_d = TRAP;
                  cause_d = CAUSE_ILLEGAL;
               end
            endcase
         end
         MEM: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
            mem_we  = cls_q.store;
            if (mem_ready) begin
               if (cls_q.load) begin
                  state_d = WB;
               end else begin
                  instr_done = 1'b1;
                  state_d    = next_fetch;
               end
            end else begin
               cnt_d = cnt_inc;
               if (timeout_hit) begin
                  state_d = TRAP;
                  cause_d = CAUSE_TIMEOUT;
               end
            end
         end
         WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            if (cls_q.load) begin
               mem_to_reg = WB_MDR;
            end else if (cls_q.jal) begin
               mem_to_reg = WB_PC_PLUS4;
            end
            state_d = next_fetch;
         end
         TRAP: begin
            state_d = TRAP;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign alu_op     = ALUOP_W'(alu_op_sel);
   assign busy       = (state_q != IDLE) && (state_q != TRAP);
   assign trap       = (state_q == TRAP);
   assign trap_cause = cause_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Next-generation RISC-V main control unit for the multicycle datapath. It replaces the purely combinational opcode decoder with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It handshakes with a shared instruction/data memory that has variable latency, and it detects illegal opcodes and memory timeouts. It sits between the IR opcode field, the ALU zero flag, the memory port and every datapath mux/enable.

Parameters:
OPCODE_W, 7, opcode field width
ALUOP_W, 3, ALUOp bus width to ALU control
MEM_TIMEOUT, 16, max wait cycles for mem_ready before trap; 0 disables the timeout
TO_CNT_W, 5, timeout counter width; must satisfy 2**TO_CNT_W > MEM_TIMEOUT

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
halt  in  1  when high, do not start a new instruction
opcode  in  OPCODE_W  IR[6:0], valid from DECODE onward
alu_zero  in  1  ALU zero flag, sampled in EXEC for branches
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write request (SW in MEM)
i_or_d  out  1  0: address=PC, 1: address=ALUOut
ir_write  out  1  load IR with memory read data
pc_write  out  1  unconditional PC update
pc_write_cond  out  1  PC update qualified by branch-taken
alu_src_a  out  1  0: PC, 1: rs1
alu_src_b  out  2  00: rs2, 01: constant 4, 10: immediate
alu_op  out  ALUOP_W  000 add, 001 branch compare, 010 R-type, 011 I-type ALU
mem_to_reg  out  2  00: ALUOut, 01: MDR, 10: PC+4
reg_write  out  1  register file write enable
busy  out  1  high in every state except IDLE and TRAP
instr_done  out  1  one-cycle pulse in the final cycle of each instruction
trap  out  1  high in TRAP
trap_cause  out  2  01: illegal opcode, 10: memory timeout; 00 otherwise

Behaviour:
- Reset (async, reset_n=0): state=IDLE, opcode_q=0, timeout counter=0, trap_cause=00. All outputs are 0 while reset is asserted and in IDLE.
- Outputs are a combinational decode of state and the latched opcode_q (Moore). Exception: in EXEC for branches, pc_write_cond is the ALU-control request and PC enable = pc_write | (pc_write_cond & alu_zero).
- IDLE: go to FETCH when halt=0.
- FETCH: mem_req=1, i_or_d=0. On mem_ready: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, alu_op=000 (PC+4), then go to DECODE. Without mem_ready, stay in FETCH.
- DECODE: latch opcode into opcode_q. Compute the branch target (alu_src_a=0, alu_src_b=10, alu_op=000). Recognised opcodes: R=0110011, I=0010011, LW=0000011, SW=0100011, BR=1100011, JAL=1101111. Any other opcode goes to TRAP with cause 01.
- EXEC:
  - R-type: a=1, b=00, op=010, then WB.
  - I-type: a=1, b=10, op=011, then WB.
  - LW/SW: a=1, b=10, op=000, then MEM.
  - BR: a=1, b=00, op=001, pc_write_cond=1; instr_done=1; then next-fetch.
  - JAL: pc_write=1 from the target computed in DECODE, then WB.
- MEM: mem_req=1, i_or_d=1, mem_we=(SW). On mem_ready: LW goes to WB; SW asserts instr_done and goes to next-fetch.
- WB: reg_write=1; mem_to_reg = 01 for LW, 10 for JAL, 00 otherwise; instr_done=1; then next-fetch.
- Next-fetch: FETCH if halt=0, else IDLE. halt is sampled only at instruction boundaries; an in-flight instruction always completes.
- Minimum cycle counts with zero-wait memory: BR 3, R/I/SW/JAL 4, LW 5. Each memory wait cycle adds one cycle.
- Timeout:
  - The counter clears on entry to FETCH/MEM and on mem_ready, and increments on each wait cycle.
  - If it reaches MEM_TIMEOUT without mem_ready, go to TRAP with cause 10.
  - If mem_ready arrives in the same cycle as the limit, mem_ready wins.
  - Counter saturates; no wrap.
- TRAP: all enables 0, trap=1, trap_cause held. Exit only through reset.
- Reset mid-instruction returns to IDLE immediately with no partial writes. reg_write and pc_write drop asynchronously.

Decomposition:
- Package riscv_ctrl_pkg:
  - ctrl_state_t enum {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP}
  - opcode localparams
  - ALUOp, alu_src_b and mem_to_reg encodings
  - trap cause codes
- Sub-module main_decoder: combinational opcode → instruction-class one-hot plus illegal flag. It is instantiated once on opcode_q and once on the live opcode for the DECODE legality check.

Test Plan:
- R-type add (0110011), mem_ready tied 1 → states FETCH, DECODE, EXEC, WB; reg_write=1 and instr_done=1 only in cycle 4; alu_op=010 in EXEC.
- LW (0000011), mem_ready delayed 3 cycles in MEM → total 8 cycles; mem_to_reg=01 in WB; i_or_d=1 for all 4 MEM cycles.
- BEQ (1100011) with alu_zero=1, then with alu_zero=0 → both complete in 3 cycles with pc_write_cond=1 in EXEC; PC enable high only in the taken case.
- Opcode 1111111 → TRAP after DECODE: trap=1, trap_cause=01, busy=0, no further mem_req; reset_n pulse returns to IDLE.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → TRAP with cause 10 after 4 wait cycles. Repeat with mem_ready arriving on the 4th cycle → DECODE, no trap.
- halt=1 asserted mid-SW, with reset_n pulsed low during a second instruction's EXEC:
  - SW completes with mem_we=1, then IDLE.
  - The reset case enters IDLE immediately with all outputs 0.
